// File: rtl/lpc_periph_mc.sv
// LPC peripheral: decodes I/O (and optionally memory) cycles, claims those
// hitting a base/mask window, hands them to a host register port with
// long-wait SYNC, and logs every completed claimed cycle into a
// first-word-fall-through capture FIFO.
module lpc_periph_mc #(
   parameter logic [15:0] IO_BASE    = 16'h0000,
   parameter logic [15:0] IO_MASK    = 16'hFFF0,
   parameter int          MEM_EN     = 0,
   parameter logic [31:0] MEM_BASE   = 32'hFF00_0000,
   parameter logic [31:0] MEM_MASK   = 32'hFF00_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          MAX_WAIT   = 16
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        lframe_i,
   inout  wire  [3:0]  lad_bus,
   output logic [31:0] addr_o,
   output logic [7:0]  wdata_o,
   output logic        we_o,
   output logic        mem_o,
   output logic        req_o,
   input  logic        ack_i,
   input  logic [7:0]  rdata_i,
   output logic [47:0] tdata_o,
   output logic        tvalid_o,
   input  logic        tready_i,
   output logic [7:0]  ovf_cnt_o,
   output logic [4:0]  state_o
);

   localparam int         AW         = $clog2(FIFO_DEPTH);
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   typedef enum logic [4:0] {
      S_IDLE    = 5'd0,  S_START = 5'd1, S_CYCTYPE = 5'd2, S_ADDR  = 5'd3,
      S_DATA_WR = 5'd4,  S_TAR1  = 5'd5, S_TAR2    = 5'd6, S_SYNC  = 5'd7,
      S_DATA_RD = 5'd8,  S_FTAR1 = 5'd9, S_FTAR2   = 5'd10
   } state_t;

   state_t      r_state, w_next;
   logic [3:1]  r_cyc;
   logic [31:0] r_addr, r_addr_o;
   logic [2:0]  r_cnt;
   logic        r_half, r_we, r_mem, r_err, r_req, r_we_o, r_mem_o;
   logic [7:0]  r_wdata, r_rdata, r_wait, r_wdata_o, r_ovf;
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic [47:0] r_fifo [FIFO_DEPTH];

   logic [3:0]  w_lad, w_lad_out;
   logic        w_oe, w_cyc_ok, w_hit, w_timeout;
   logic        w_empty, w_full, w_push, w_pop, w_wr_en;
   logic [47:0] w_cap_word;

   assign w_lad     = lad_bus;
   assign lad_bus   = w_oe ? w_lad_out : 4'bzzzz;
   // Cycle type nibble: 00xx = I/O, 01xx = memory (only when enabled).
   assign w_cyc_ok  = (r_cyc[3:2] == 2'b00) || ((r_cyc[3:2] == 2'b01) && (MEM_EN != 0));
   assign w_hit     = r_mem ? (((r_addr ^ MEM_BASE) & MEM_MASK) == 32'd0)
                            : (((r_addr[15:0] ^ IO_BASE) & IO_MASK) == 16'd0);
   assign w_timeout = (r_wait == MAX_WAIT_C);

   // State register
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic; a low LFRAME# overrides every state
   always_comb begin
      w_next = r_state;
      if (!lframe_i) begin
         w_next = (w_lad == 4'h0) ? S_START : S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    w_next = S_IDLE;
            S_START:   w_next = S_CYCTYPE;
            S_CYCTYPE: w_next = w_cyc_ok ? S_ADDR : S_IDLE;
            S_ADDR:    if (r_cnt == 3'd0) w_next = r_we ? S_DATA_WR : S_TAR1;
            S_DATA_WR: if (r_half) w_next = S_TAR1;
            S_TAR1:    w_next = S_TAR2;
            S_TAR2:    w_next = w_hit ? S_SYNC : S_IDLE;
            S_SYNC:    if (ack_i || w_timeout) w_next = r_we ? S_FTAR1 : S_DATA_RD;
            S_DATA_RD: if (r_half) w_next = S_FTAR1;
            S_FTAR1:   w_next = S_FTAR2;
            S_FTAR2:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   // LAD drive; SYNC value follows ack_i combinationally for zero-latency ready
   always_comb begin
      w_oe      = 1'b0;
      w_lad_out = 4'h0;
      if (lframe_i) begin
         case (r_state)
            S_SYNC: begin
               w_oe      = 1'b1;
               w_lad_out = ack_i ? 4'h0 : (w_timeout ? 4'hA : 4'h6);
            end
            S_DATA_RD: begin
               w_oe      = 1'b1;
               w_lad_out = r_half ? r_rdata[7:4] : r_rdata[3:0];
            end
            S_FTAR1: begin
               w_oe      = 1'b1;
               w_lad_out = 4'hF;
            end
            default: ;
         endcase
      end
   end

   // Cycle datapath: decode fields, host handshake, wait counting
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         r_cyc <= '0;      r_addr <= '0;    r_cnt <= '0;     r_half <= 1'b0;
         r_we <= 1'b0;     r_mem <= 1'b0;   r_err <= 1'b0;   r_req <= 1'b0;
         r_wdata <= '0;    r_rdata <= '0;   r_wait <= '0;
         r_addr_o <= '0;   r_we_o <= 1'b0;  r_mem_o <= 1'b0; r_wdata_o <= '0;
      end else if (!lframe_i) begin
         r_req <= 1'b0;
      end else begin
         case (r_state)
            S_START: r_cyc <= w_lad[3:1];
            S_CYCTYPE: begin
               r_mem   <= r_cyc[2];
               r_we    <= r_cyc[1];
               r_addr  <= {28'd0, w_lad};
               r_cnt   <= r_cyc[2] ? 3'd6 : 3'd2;
               r_half  <= 1'b0;
               r_err   <= 1'b0;
               r_wdata <= 8'h00;
            end
            S_ADDR: begin
               r_addr <= {r_addr[27:0], w_lad};
               if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            end
            S_DATA_WR: begin
               if (!r_half) r_wdata[3:0] <= w_lad;
               else         r_wdata[7:4] <= w_lad;
               r_half <= ~r_half;
            end
            S_TAR2: begin
               r_wait <= 8'd0;
               if (w_hit) begin
                  r_req     <= 1'b1;
                  r_addr_o  <= r_addr;
                  r_we_o    <= r_we;
                  r_mem_o   <= r_mem;
                  r_wdata_o <= r_wdata;
               end
            end
            S_SYNC: begin
               if (ack_i) begin
                  r_req   <= 1'b0;
                  r_rdata <= rdata_i;
               end else if (w_timeout) begin
                  r_req   <= 1'b0;
                  r_err   <= 1'b1;
                  r_rdata <= 8'hFF;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            S_DATA_RD: r_half <= ~r_half;
            default: ;
         endcase
      end
   end

   // Capture FIFO control: a pop frees the slot for a same-cycle push when full
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push     = (r_state == S_FTAR2) && lframe_i;
   assign w_pop      = !w_empty && tready_i;
   assign w_wr_en    = w_push && (!w_full || w_pop);
   assign w_cap_word = {4'd0, r_err, r_mem, r_we, 1'b0, r_addr, r_we ? r_wdata : r_rdata};

   // FIFO pointers and saturating drop counter
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && w_full && !w_pop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk_i) begin
      if (w_wr_en) r_fifo[r_wr_ptr[AW-1:0]] <= w_cap_word;
   end

   assign tdata_o   = r_fifo[r_rd_ptr[AW-1:0]];
   assign tvalid_o  = !w_empty;
   assign ovf_cnt_o = r_ovf;
   assign req_o     = r_req && lframe_i;
   assign addr_o    = r_addr_o;
   assign wdata_o   = r_wdata_o;
   assign we_o      = r_we_o;
   assign mem_o     = r_mem_o;
   assign state_o   = r_state;

endmodule

// File: tb/tb_lpc_periph_mc.sv
// Directed bench for lpc_periph_mc: drives LPC frames nibble by nibble,
// checks LAD/host-port behaviour inline and capture words via a scoreboard.
module tb_lpc_periph_mc;

   localparam int         MAXW = 4;
   // The bus carries a pull-up, so a released LAD reads back as F.
   localparam logic [3:0] REL  = 4'hF;

   logic        clk = 1'b0, nrst = 1'b0, lframe = 1'b1, ack = 1'b0, tready = 1'b1;
   logic        tb_oe = 1'b0;
   logic [3:0]  tb_lad = 4'h0;
   logic [7:0]  rdata = 8'h00;
   wire  [3:0]  lad_bus;
   logic [31:0] addr_o;
   logic [7:0]  wdata_o, ovf_cnt_o;
   logic        we_o, mem_o, req_o, tvalid_o;
   logic [47:0] tdata_o;
   logic [4:0]  state_o;

   int          n_tests = 0, n_fail = 0;
   logic [47:0] sb [$];

   assign lad_bus = tb_oe ? tb_lad : 4'bzzzz;
   pullup (lad_bus);

   always #5 clk = ~clk;

   lpc_periph_mc #(
      .IO_BASE(16'h0060), .IO_MASK(16'hFFF0), .MEM_EN(1),
      .MEM_BASE(32'hFF00_0000), .MEM_MASK(32'hFF00_0000),
      .FIFO_DEPTH(2), .MAX_WAIT(MAXW)
   ) dut (
      .clk_i(clk), .nrst_i(nrst), .lframe_i(lframe), .lad_bus(lad_bus),
      .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o), .mem_o(mem_o),
      .req_o(req_o), .ack_i(ack), .rdata_i(rdata), .tdata_o(tdata_o),
      .tvalid_o(tvalid_o), .tready_i(tready), .ovf_cnt_o(ovf_cnt_o),
      .state_o(state_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] mkword(input logic err, input logic mem, input logic wr,
                                          input logic [31:0] a, input logic [7:0] d);
      return {4'd0, err, mem, wr, 1'b0, a, d};
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic nib(input logic fr, input logic [3:0] v);
      step();
      lframe = fr; tb_lad = v; tb_oe = 1'b1;
   endtask

   // START, CYCTYPE, address, optional write data, TAR1; leaves bench released in TAR2
   task automatic header(input logic mem, input logic wr, input logic [31:0] a, input logic [7:0] wd);
      int n;
      n = mem ? 8 : 4;
      nib(1'b0, 4'h0);
      nib(1'b1, {1'b0, mem, wr, 1'b0});
      for (int i = n - 1; i >= 0; i--) nib(1'b1, a[4*i +: 4]);
      if (wr) begin
         nib(1'b1, wd[3:0]);
         nib(1'b1, wd[7:4]);
      end
      nib(1'b1, 4'hF);
      step();
      tb_oe = 1'b0;
      @(negedge clk);
      chk("req_before_sync", req_o, 1'b0);
   endtask

   // Full cycle; ack_after < 0 means the host never acknowledges
   task automatic lpc_cycle(input logic mem, input logic wr, input logic [31:0] a,
                            input logic [7:0] wd, input int ack_after, input logic [7:0] rd,
                            input logic hit, input logic keep, input logic rdy_final);
      int         w;
      logic       done, err;
      logic [3:0] exp;
      logic [7:0] d;
      header(mem, wr, a, wd);
      if (!hit) begin
         for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("miss_lad", lad_bus, REL);
            chk("miss_req", req_o, 1'b0);
         end
         return;
      end
      w = 0; done = 1'b0; err = 1'b0;
      while (!done) begin
         step();
         ack   = (ack_after >= 0) && (w >= ack_after);
         rdata = rd;
         @(negedge clk);
         if (w == 0) begin
            chk("req_sync", req_o, 1'b1);
            chk("addr_o", addr_o, a);
            chk("we_o", we_o, wr);
            chk("mem_o", mem_o, mem);
            if (wr) chk("wdata_o", wdata_o, wd);
         end
         if (ack) begin
            exp = 4'h0; done = 1'b1;
         end else if (w == MAXW) begin
            exp = 4'hA; err = 1'b1; done = 1'b1;
         end else begin
            exp = 4'h6;
         end
         chk("sync_nibble", lad_bus, exp);
         w++;
      end
      d = wr ? wd : (err ? 8'hFF : rd);
      step();
      ack = err;       // a late acknowledge after an error must be ignored
      rdata = 8'h00;
      @(negedge clk);
      chk("req_after_sync", req_o, 1'b0);
      if (!wr) begin
         chk("rd_lo", lad_bus, d[3:0]);
         step(); ack = 1'b0;
         @(negedge clk);
         chk("rd_hi", lad_bus, d[7:4]);
         step();
         @(negedge clk);
      end
      chk("final_tar1", lad_bus, 4'hF);
      step();
      ack = 1'b0;
      if (rdy_final) tready = 1'b1;
      @(negedge clk);
      chk("final_tar2_released", lad_bus, REL);
      if (keep) sb.push_back(mkword(err, mem, wr, a, d));
   endtask

   // Capture monitor: every handshake must match the oldest expected word
   always @(negedge clk) begin
      if (nrst && tvalid_o && tready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL unexpected_capture: observed %h expected none", tdata_o);
         end else begin
            chk("capture", tdata_o, sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog: simulation did not finish");
   end

   initial begin
      int t;
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", req_o, 1'b0);
      chk("rst_we", we_o, 1'b0);
      chk("rst_mem", mem_o, 1'b0);
      chk("rst_tvalid", tvalid_o, 1'b0);
      chk("rst_addr", addr_o, 32'd0);
      chk("rst_wdata", wdata_o, 8'd0);
      chk("rst_ovf", ovf_cnt_o, 8'd0);
      chk("rst_lad", lad_bus, REL);
      step(); nrst = 1'b1;
      step();

      // I/O write hit, ack after three waits
      lpc_cycle(1'b0, 1'b1, 32'h0000_0062, 8'h5A, 3, 8'h00, 1'b1, 1'b1, 1'b0);
      // I/O read hit, immediate ack
      lpc_cycle(1'b0, 1'b0, 32'h0000_0064, 8'h00, 0, 8'hC3, 1'b1, 1'b1, 1'b0);
      // I/O read miss
      lpc_cycle(1'b0, 1'b0, 32'h0000_0080, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("miss_no_capture", tvalid_o, 1'b0);
      // Memory write, host never answers -> error SYNC
      lpc_cycle(1'b1, 1'b1, 32'hFF00_1234, 8'h11, -1, 8'h00, 1'b1, 1'b1, 1'b0);
      // Memory read timeout -> FF data
      lpc_cycle(1'b1, 1'b0, 32'hFF00_0010, 8'h00, -1, 8'h99, 1'b1, 1'b1, 1'b0);
      // Memory read hit with a wait
      lpc_cycle(1'b1, 1'b0, 32'hFF12_0008, 8'h00, 1, 8'h3E, 1'b1, 1'b1, 1'b0);

      // Reserved cycle type is ignored
      nib(1'b0, 4'h0); nib(1'b1, 4'h8);
      nib(1'b1, 4'h0); nib(1'b1, 4'h0); nib(1'b1, 4'h6); nib(1'b1, 4'h2);
      nib(1'b1, 4'hF); step(); tb_oe = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(); @(negedge clk);
         chk("badcyc_req", req_o, 1'b0);
         chk("badcyc_lad", lad_bus, REL);
      end

      // Abort during the last address nibble with non-zero LAD -> IDLE
      nib(1'b0, 4'h0); nib(1'b1, 4'h2);
      nib(1'b1, 4'h0); nib(1'b1, 4'h0); nib(1'b1, 4'h6);
      nib(1'b0, 4'h5);
      step(); lframe = 1'b1; tb_oe = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_idle_req", req_o, 1'b0);
         chk("abort_idle_tvalid", tvalid_o, 1'b0);
         step();
      end
      lpc_cycle(1'b0, 1'b1, 32'h0000_006F, 8'hA5, 0, 8'h00, 1'b1, 1'b1, 1'b0);

      // Abort with LAD = 0 -> START; the following frame decodes normally
      nib(1'b0, 4'h0); nib(1'b1, 4'h0);
      nib(1'b1, 4'h0); nib(1'b1, 4'h0); nib(1'b1, 4'h6);
      nib(1'b0, 4'h0);
      @(negedge clk);
      chk("abort_start_req", req_o, 1'b0);
      lpc_cycle(1'b0, 1'b0, 32'h0000_0061, 8'h00, 2, 8'h7E, 1'b1, 1'b1, 1'b0);

      // Reset in the middle of SYNC releases LAD and drops req at once
      header(1'b0, 1'b1, 32'h0000_0063, 8'h77);
      step(); ack = 1'b0;
      @(negedge clk);
      chk("midrst_sync", lad_bus, 4'h6);
      chk("midrst_req_pre", req_o, 1'b1);
      #2 nrst = 1'b0;
      #1;
      chk("midrst_lad", lad_bus, REL);
      chk("midrst_req", req_o, 1'b0);
      chk("midrst_addr", addr_o, 32'd0);
      step(); nrst = 1'b1;
      lpc_cycle(1'b0, 1'b1, 32'h0000_0065, 8'h3C, 0, 8'h00, 1'b1, 1'b1, 1'b0);
      repeat (3) step();

      // FIFO overflow: depth 2, consumer stalled, three writes
      tready = 1'b0;
      lpc_cycle(1'b0, 1'b1, 32'h0000_0060, 8'h01, 0, 8'h00, 1'b1, 1'b1, 1'b0);
      lpc_cycle(1'b0, 1'b1, 32'h0000_0061, 8'h02, 0, 8'h00, 1'b1, 1'b1, 1'b0);
      lpc_cycle(1'b0, 1'b1, 32'h0000_0062, 8'h03, 0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(); @(negedge clk);
      chk("ovf_tvalid", tvalid_o, 1'b1);
      chk("ovf_count", ovf_cnt_o, 8'd1);
      // Push into a full FIFO on the same cycle the consumer pops
      lpc_cycle(1'b0, 1'b1, 32'h0000_0063, 8'h04, 0, 8'h00, 1'b1, 1'b1, 1'b1);

      // Drain
      t = 0;
      while (sb.size() != 0 && t < 50) begin
         step(); t++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL drain_timeout: observed %0d words pending expected 0", sb.size());
      end
      step(); @(negedge clk);
      chk("ovf_final", ovf_cnt_o, 8'd1);
      chk("empty_final", tvalid_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
